// File: rtl/snake_body_engine.sv
// Snake game-state stage: segment body, movement, collisions, score.
// Optional SNAKE_WRAP_EN: board edges wrap instead of killing.
module snake_body_engine #(
    parameter int MAX_LEN   = 100,
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 10,
    parameter int START_LEN = 3,
    parameter int START_X   = 4,
    parameter int START_Y   = 5,
    parameter int SCORE_MAX = 999
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    restart,
    input  logic                    step,
    input  logic [1:0]              dir,
    input  logic [31:0]             food_x,
    input  logic [31:0]             food_y,
    output logic [32*MAX_LEN-1:0]   x_values,
    output logic [32*MAX_LEN-1:0]   y_values,
    output logic [31:0]             length,
    output logic                    ate,
    output logic                    game_done,
    output logic [31:0]             score,
    output logic [31:0]             high_score
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DEAD
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] seg_x_q [MAX_LEN];
    logic [31:0] seg_x_d [MAX_LEN];
    logic [31:0] seg_y_q [MAX_LEN];
    logic [31:0] seg_y_d [MAX_LEN];
    logic [31:0] length_q, length_d;
    logic [31:0] score_q, score_d;
    logic [31:0] high_q, high_d;
    logic [1:0]  dir_q, dir_d;
    logic        ate_q, ate_d;

    logic [1:0]  dir_eff;
    logic [31:0] nh_x_raw, nh_y_raw;
    logic [31:0] nh_x, nh_y;
    logic        wall_hit;
    logic        self_hit;
    logic        eat;
    logic        grow;
    logic [31:0] score_inc;
    logic [31:0] live_len;

    function automatic logic [31:0] init_x(input int i);
        return (i < START_LEN) ? 32'(START_X - i) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] init_y(input int i);
        return (i < START_LEN) ? 32'(START_Y) : 32'hFFFF_FFFF;
    endfunction

    // A request exactly opposite the current heading is dropped
    always_comb begin
        dir_eff = ((dir ^ 2'd2) == dir_q) ? dir_q : dir;
        nh_x_raw = seg_x_q[0];
        nh_y_raw = seg_y_q[0];
        unique case (dir_eff)
            DIR_UP:    nh_y_raw = seg_y_q[0] - 32'd1;
            DIR_RIGHT: nh_x_raw = seg_x_q[0] + 32'd1;
            DIR_DOWN:  nh_y_raw = seg_y_q[0] + 32'd1;
            DIR_LEFT:  nh_x_raw = seg_x_q[0] - 32'd1;
            default:   nh_x_raw = seg_x_q[0];
        endcase
    end

`ifdef SNAKE_WRAP_EN
    always_comb begin
        nh_x = nh_x_raw;
        nh_y = nh_y_raw;
        if (nh_x_raw == 32'(GRID_W)) begin
            nh_x = '0;
        end else if (nh_x_raw == 32'hFFFF_FFFF) begin
            nh_x = 32'(GRID_W - 1);
        end
        if (nh_y_raw == 32'(GRID_H)) begin
            nh_y = '0;
        end else if (nh_y_raw == 32'hFFFF_FFFF) begin
            nh_y = 32'(GRID_H - 1);
        end
        wall_hit = 1'b0;
    end
`else
    // Underflow lands at 32'hFFFFFFFF, which the unsigned compare also catches
    always_comb begin
        nh_x = nh_x_raw;
        nh_y = nh_y_raw;
        wall_hit = (nh_x_raw >= 32'(GRID_W)) || (nh_y_raw >= 32'(GRID_H));
    end
`endif

    // The tail vacates its tile on a plain move, so it only blocks when growing
    always_comb begin
        eat = (nh_x == food_x) && (nh_y == food_y);
        grow = eat && (length_q < 32'(MAX_LEN));
        live_len = length_q + {31'd0, grow};
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y)
                && ((32'(i) + 32'd1) < live_len)) begin
                self_hit = 1'b1;
            end
        end
        score_inc = (score_q >= 32'(SCORE_MAX)) ? score_q : score_q + 32'd1;
    end

    always_comb begin
        state_d  = state_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        length_d = length_q;
        score_d  = score_q;
        high_d   = high_q;
        dir_d    = dir_q;
        ate_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                dir_d = dir_eff;
                if (step) begin
                    if (wall_hit || self_hit) begin
                        state_d = S_DEAD;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            if (32'(i) < live_len) begin
                                seg_x_d[i] = seg_x_q[i-1];
                                seg_y_d[i] = seg_y_q[i-1];
                            end
                        end
                        seg_x_d[0] = nh_x;
                        seg_y_d[0] = nh_y;
                        if (grow) begin
                            length_d = length_q + 32'd1;
                        end
                        if (eat) begin
                            ate_d   = 1'b1;
                            score_d = score_inc;
                            if (score_inc > high_q) begin
                                high_d = score_inc;
                            end
                        end
                    end
                end
            end
            S_DEAD: begin
                if (restart) begin
                    state_d  = S_IDLE;
                    length_d = 32'(START_LEN);
                    score_d  = '0;
                    dir_d    = DIR_RIGHT;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = init_x(i);
                        seg_y_d[i] = init_y(i);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            length_q <= 32'(START_LEN);
            score_q  <= '0;
            high_q   <= '0;
            dir_q    <= DIR_RIGHT;
            ate_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            score_q  <= score_d;
            high_q   <= high_d;
            dir_q    <= dir_d;
            ate_q    <= ate_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign x_values[32*g +: 32] = seg_x_q[g];
        assign y_values[32*g +: 32] = seg_y_q[g];
    end

    assign length     = length_q;
    assign ate        = ate_q;
    assign game_done  = (state_q == S_DEAD);
    assign score      = score_q;
    assign high_score = high_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: directed moves, eating,
// reversal, wall/self collision, restart and reset-during-step.
module tb_snake_body_engine;

    localparam int MAX_LEN = 100;
    localparam logic [31:0] M1 = 32'hFFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  restart;
    logic                  step;
    logic [1:0]            dir;
    logic [31:0]           food_x;
    logic [31:0]           food_y;
    logic [32*MAX_LEN-1:0] x_values;
    logic [32*MAX_LEN-1:0] y_values;
    logic [31:0]           length;
    logic                  ate;
    logic                  game_done;
    logic [31:0]           score;
    logic [31:0]           high_score;

    snake_body_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .restart    (restart),
        .step       (step),
        .dir        (dir),
        .food_x     (food_x),
        .food_y     (food_y),
        .x_values   (x_values),
        .y_values   (y_values),
        .length     (length),
        .ate        (ate),
        .game_done  (game_done),
        .score      (score),
        .high_score (high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        string       name;
        logic [31:0] hx, hy, len;
        logic        ate, done;
        logic [31:0] sc, hs;
        int          slot;
        logic [31:0] sx, sy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cyc_in(input logic rs, input logic st, input logic rr,
                          input logic sp, input logic [1:0] d,
                          input logic [31:0] fx, input logic [31:0] fy);
        @(negedge clk);
        reset = rs; start = st; restart = rr; step = sp; dir = d;
        food_x = fx; food_y = fy;
    endtask

    task automatic ex(input string nm, input logic [31:0] hx,
                      input logic [31:0] hy, input logic [31:0] len,
                      input logic a, input logic dn, input logic [31:0] sc,
                      input logic [31:0] hs, input int slot,
                      input logic [31:0] sx, input logic [31:0] sy);
        exp_t e;
        e.tag = cyc + 1; e.name = nm;
        e.hx = hx; e.hy = hy; e.len = len; e.ate = a; e.done = dn;
        e.sc = sc; e.hs = hs; e.slot = slot; e.sx = sx; e.sy = sy;
        q.push_back(e);
    endtask

    // Monitor: checks every expectation whose response cycle has arrived
    initial begin
        exp_t e;
        logic [31:0] ax, ay;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tag <= cyc) begin
                e = q.pop_front();
                ax = x_values[32*e.slot +: 32];
                ay = y_values[32*e.slot +: 32];
                n_chk++;
                if (x_values[31:0] !== e.hx || y_values[31:0] !== e.hy
                    || length !== e.len || ate !== e.ate
                    || game_done !== e.done || score !== e.sc
                    || high_score !== e.hs || ax !== e.sx || ay !== e.sy) begin
                    n_fail++;
                    $display("FAIL %s: got head=(%0d,%0d) len=%0d ate=%0b done=%0b sc=%0d hs=%0d s%0d=(%0h,%0h) want head=(%0d,%0d) len=%0d ate=%0b done=%0b sc=%0d hs=%0d s%0d=(%0h,%0h)",
                             e.name, x_values[31:0], y_values[31:0], length,
                             ate, game_done, score, high_score, e.slot, ax, ay,
                             e.hx, e.hy, e.len, e.ate, e.done, e.sc, e.hs,
                             e.slot, e.sx, e.sy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; restart = 1'b0; step = 1'b0;
        dir = 2'd1; food_x = 32'd9; food_y = 32'd9;

        cyc_in(1, 0, 0, 0, 1, 9, 9);
        ex("reset_slot3", 4, 5, 3, 0, 0, 0, 0, 3, M1, M1);
        cyc_in(1, 0, 0, 0, 1, 9, 9);
        ex("reset_slot2", 4, 5, 3, 0, 0, 0, 0, 2, 2, 5);

        cyc_in(0, 1, 0, 1, 1, 9, 9);
        ex("start_step_ignored", 4, 5, 3, 0, 0, 0, 0, 1, 3, 5);
        cyc_in(0, 0, 0, 1, 1, 9, 9);
        ex("step1", 5, 5, 3, 0, 0, 0, 0, 1, 4, 5);
        cyc_in(0, 0, 0, 1, 1, 9, 9);
        ex("step2", 6, 5, 3, 0, 0, 0, 0, 2, 4, 5);
        cyc_in(0, 0, 0, 1, 1, 9, 9);
        ex("step3_slot3", 7, 5, 3, 0, 0, 0, 0, 3, M1, M1);
        ex("step3_slot1", 7, 5, 3, 0, 0, 0, 0, 1, 6, 5);
        cyc_in(0, 0, 0, 1, 1, 9, 9);
        ex("step4", 8, 5, 3, 0, 0, 0, 0, 2, 6, 5);
        cyc_in(0, 0, 0, 1, 1, 9, 9);
        ex("step5", 9, 5, 3, 0, 0, 0, 0, 2, 7, 5);
        cyc_in(0, 0, 0, 1, 1, 9, 9);
`ifdef SNAKE_WRAP_EN
        ex("wrap_x", 0, 5, 3, 0, 0, 0, 0, 1, 9, 5);
        cyc_in(1, 0, 0, 0, 1, 9, 9);
        ex("wrap_reset", 4, 5, 3, 0, 0, 0, 0, 3, M1, M1);
`else
        ex("wall_hit", 9, 5, 3, 0, 1, 0, 0, 2, 7, 5);
        cyc_in(0, 1, 0, 1, 1, 9, 9);
        ex("dead_ignores", 9, 5, 3, 0, 1, 0, 0, 1, 8, 5);
        cyc_in(0, 0, 1, 1, 1, 9, 9);
        ex("restart1", 4, 5, 3, 0, 0, 0, 0, 2, 2, 5);
`endif

        cyc_in(0, 1, 0, 0, 1, 5, 5);
        ex("start_b", 4, 5, 3, 0, 0, 0, 0, 3, M1, M1);
        cyc_in(0, 0, 0, 1, 1, 5, 5);
        ex("eat_grow", 5, 5, 4, 1, 0, 1, 1, 3, 2, 5);
        cyc_in(0, 0, 0, 0, 1, 9, 9);
        ex("ate_drops", 5, 5, 4, 0, 0, 1, 1, 1, 4, 5);
        cyc_in(0, 0, 0, 1, 3, 9, 9);
        ex("reversal_ignored", 6, 5, 4, 0, 0, 1, 1, 1, 5, 5);
        cyc_in(0, 0, 0, 1, 1, 7, 5);
        ex("grow_to5", 7, 5, 5, 1, 0, 2, 2, 4, 3, 5);
        cyc_in(0, 0, 0, 1, 2, 0, 0);
        ex("turn_down", 7, 6, 5, 0, 0, 2, 2, 1, 7, 5);
        cyc_in(0, 0, 0, 1, 3, 0, 0);
        ex("turn_left", 6, 6, 5, 0, 0, 2, 2, 2, 7, 5);
        cyc_in(0, 0, 0, 1, 0, 0, 0);
        ex("self_hit", 6, 6, 5, 0, 1, 2, 2, 3, 6, 5);
        cyc_in(0, 1, 0, 1, 2, 0, 0);
        ex("dead_frozen", 6, 6, 5, 0, 1, 2, 2, 4, 5, 5);
        cyc_in(0, 0, 1, 0, 1, 0, 0);
        ex("restart_keeps_hs", 4, 5, 3, 0, 0, 0, 2, 3, M1, M1);

        cyc_in(0, 1, 0, 0, 1, 5, 5);
        ex("start_c", 4, 5, 3, 0, 0, 0, 2, 2, 2, 5);
        cyc_in(1, 0, 0, 1, 1, 5, 5);
        ex("reset_on_step", 4, 5, 3, 0, 0, 0, 0, 3, M1, M1);
        cyc_in(0, 0, 0, 1, 1, 5, 5);
        ex("idle_after_reset", 4, 5, 3, 0, 0, 0, 0, 1, 3, 5);
        cyc_in(0, 1, 0, 0, 1, 5, 5);
        ex("start_d", 4, 5, 3, 0, 0, 0, 0, 2, 2, 5);
        cyc_in(0, 0, 0, 1, 1, 5, 5);
        ex("eat_after_reset", 5, 5, 4, 1, 0, 1, 1, 3, 2, 5);
        cyc_in(0, 0, 0, 0, 1, 9, 9);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
